// File: rtl/cordic_pkg.sv
// Shared definitions for the CORDIC request scheduler: default engine
// geometry and the scheduler FSM encoding.
package cordic_pkg;

  localparam int CORDIC_DATA_WIDTH = 8;
  localparam int CORDIC_LATENCY    = 12;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } cordic_sched_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: scans upward from last_grant+1,
// wrapping modulo NUM_REQ, and returns the first active requester.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_grant,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx
);

  logic             found;
  logic [IDX_W-1:0] cand;

  // NOTE: every output and temporary gets a default before the loop;
  // a path that leaves one unassigned would infer a latch.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = IDX_W'((int'(last_grant) + i) % NUM_REQ);
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/cordic_sched.sv
// Time-shares one fixed-latency CORDIC engine between NUM_REQ requesters:
// round-robin acceptance, one operation in flight, held response.
module cordic_sched
  import cordic_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = CORDIC_DATA_WIDTH,
  parameter int LATENCY    = CORDIC_LATENCY
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_angle,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [DATA_WIDTH-1:0]         eng_angle,
  output logic                          eng_start,
  input  logic [DATA_WIDTH-1:0]         eng_cos,
  input  logic [DATA_WIDTH-1:0]         eng_sin,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_cos,
  output logic [DATA_WIDTH-1:0]         rsp_sin,
  input  logic [NUM_REQ-1:0]            rsp_ready
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(LATENCY + 1);

  cordic_sched_state_t  state;
  logic [CNT_W-1:0]     cnt;
  logic [IDX_W-1:0]     grant_id;
  logic [IDX_W-1:0]     last_grant;

  logic [NUM_REQ-1:0]    arb_grant;
  logic [IDX_W-1:0]      arb_idx;
  logic [DATA_WIDTH-1:0] angle_arr [NUM_REQ];
  logic                  accept;
  logic                  rsp_done;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .req        (req_valid),
    .last_grant (last_grant),
    .grant      (arb_grant),
    .grant_idx  (arb_idx)
  );

  always_comb begin
    for (int k = 0; k < NUM_REQ; k++) begin
      angle_arr[k] = req_angle[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Arbitration is visible only while idle; req_valid is ignored otherwise.
  assign req_ready = (state == ST_IDLE) ? arb_grant : '0;
  assign accept    = (state == ST_IDLE) && (|req_valid);
  assign rsp_done  = (state == ST_RESP) && rsp_ready[grant_id];

  always_comb begin
    rsp_valid = '0;
    if (state == ST_RESP) begin
      rsp_valid[grant_id] = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  // NOTE: the asynchronous reset clears all state, so an operation aborted
  // mid-BUSY or mid-RESP can never surface a stale response afterwards.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      grant_id   <= '0;
      last_grant <= IDX_W'(NUM_REQ - 1);
      eng_angle  <= '0;
      eng_start  <= 1'b0;
      rsp_cos    <= '0;
      rsp_sin    <= '0;
    end else begin
      eng_start <= accept;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            grant_id  <= arb_idx;
            eng_angle <= angle_arr[arb_idx];
            cnt       <= CNT_W'(LATENCY - 1);
            state     <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (cnt == '0) begin
            rsp_cos <= eng_cos;
            rsp_sin <= eng_sin;
            state   <= ST_RESP;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        ST_RESP: begin
          if (rsp_done) begin
            last_grant <= grant_id;
            state      <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_sched.sv
// Randomized and directed bench for cordic_sched against a transaction-level
// model that tracks ownership and due cycles rather than FSM states.
module tb_cordic_sched;

  localparam int N  = 4;
  localparam int DW = cordic_pkg::CORDIC_DATA_WIDTH;
  localparam int L  = cordic_pkg::CORDIC_LATENCY;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N*DW-1:0] req_angle = '0;
  logic [N-1:0]    req_ready;
  logic [DW-1:0]   eng_angle;
  logic            eng_start;
  logic [DW-1:0]   eng_cos = '0;
  logic [DW-1:0]   eng_sin = '0;
  logic [N-1:0]    rsp_valid;
  logic [DW-1:0]   rsp_cos;
  logic [DW-1:0]   rsp_sin;
  logic [N-1:0]    rsp_ready = '0;

  cordic_sched #(.NUM_REQ(N), .DATA_WIDTH(DW), .LATENCY(L)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_angle (req_angle),
    .req_ready (req_ready),
    .eng_angle (eng_angle),
    .eng_start (eng_start),
    .eng_cos   (eng_cos),
    .eng_sin   (eng_sin),
    .rsp_valid (rsp_valid),
    .rsp_cos   (rsp_cos),
    .rsp_sin   (rsp_sin),
    .rsp_ready (rsp_ready)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  // Reference model: one operation in flight, owner plus acceptance cycle.
  bit            m_busy;
  int            m_owner;
  int            m_acc;
  int            m_last;
  logic [DW-1:0] m_angle, m_cos, m_sin;

  // Acceptances observed on the DUT handshake.
  int acc_cyc[$];
  int acc_id[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int rr_winner(input logic [N-1:0] req, input int last);
    for (int i = 1; i <= N; i++) begin
      if (req[(last + i) % N]) return (last + i) % N;
    end
    return -1;
  endfunction

  function automatic void model_reset();
    m_busy  = 1'b0;
    m_owner = 0;
    m_acc   = 0;
    m_last  = N - 1;
    m_angle = '0;
    m_cos   = '0;
    m_sin   = '0;
  endfunction

  // One clock cycle: randomize engine outputs, compare, then advance model.
  task automatic step();
    int            win;
    bit            in_resp;
    logic [N-1:0]  exp_ready, exp_rv;
    eng_cos = DW'($urandom);
    eng_sin = DW'($urandom);
    #1;
    win       = rr_winner(req_valid, m_last);
    in_resp   = m_busy && (cyc >= m_acc + L + 1);
    exp_ready = (!m_busy && win >= 0) ? N'(1 << win) : '0;
    exp_rv    = in_resp ? N'(1 << m_owner) : '0;
    check("req_ready", 32'(req_ready), 32'(exp_ready));
    check("eng_start", 32'(eng_start), 32'(m_busy && cyc == m_acc + 1));
    check("eng_angle", 32'(eng_angle), 32'(m_angle));
    check("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
    check("rsp_cos",   32'(rsp_cos),   32'(m_cos));
    check("rsp_sin",   32'(rsp_sin),   32'(m_sin));
    for (int k = 0; k < N; k++) begin
      if (req_valid[k] && req_ready[k]) begin
        acc_cyc.push_back(cyc);
        acc_id.push_back(k);
      end
    end
    @(posedge clk);
    if (!m_busy) begin
      if (win >= 0) begin
        m_busy  = 1'b1;
        m_owner = win;
        m_acc   = cyc;
        m_angle = req_angle[win*DW +: DW];
      end
    end else begin
      if (cyc == m_acc + L) begin
        m_cos = eng_cos;
        m_sin = eng_sin;
      end
      if (in_resp && rsp_ready[m_owner]) begin
        m_busy = 1'b0;
        m_last = m_owner;
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  // Asserts reset mid-cycle and checks that outputs clear without a clock edge.
  task automatic do_reset(input string tag);
    req_valid = '0;
    #2 rst = 1'b0;
    #1;
    check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    check({tag, "_eng_start"}, 32'(eng_start), 32'd0);
    check({tag, "_eng_angle"}, 32'(eng_angle), 32'd0);
    check({tag, "_rsp_cos"},   32'(rsp_cos),   32'd0);
    check({tag, "_rsp_sin"},   32'(rsp_sin),   32'd0);
    check({tag, "_req_ready"}, 32'(req_ready), 32'd0);
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    acc_cyc.delete();
    acc_id.delete();
  endtask

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    do_reset("por");

    // Single request from requester 0 with a known angle.
    req_angle = {N{8'b0011_0010}};
    req_valid = 4'b0001;
    rsp_ready = 4'b1111;
    step();
    req_valid = '0;
    step();
    check("single_start", 32'(eng_start), 32'd0);
    check("single_angle", 32'(eng_angle), 32'b0011_0010);
    repeat (L + 2) step();

    // Contention: all requesters, ready tied high.
    do_reset("cont");
    req_valid = 4'b1111;
    rsp_ready = 4'b1111;
    for (int k = 0; k < N; k++) req_angle[k*DW +: DW] = DW'(8'h10 + k);
    repeat (5 * (L + 2) + 1) step();
    check("cont_count", 32'(acc_id.size() >= 5), 32'd1);
    if (acc_id.size() >= 5) begin
      for (int i = 0; i < 5; i++) begin
        check("cont_order", 32'(acc_id[i]), 32'(i % N));
        if (i > 0) check("cont_spacing", 32'(acc_cyc[i] - acc_cyc[i-1]), 32'(L + 2));
      end
    end

    // Backpressure on owner 2, others keep requesting.
    do_reset("bp");
    req_valid = 4'b0100;
    rsp_ready = 4'b1011;
    step();
    for (int i = 0; i < L + 1 + 20; i++) begin
      req_valid = N'($urandom);
      step();
    end
    check("bp_hold", 32'(rsp_valid), 32'b0100);
    req_valid = '0;
    rsp_ready = 4'b0100;
    step();
    step();
    check("bp_release", 32'(rsp_valid), 32'd0);

    // Foreign ready bits must not complete owner 1's response.
    do_reset("fr");
    req_valid = 4'b0010;
    rsp_ready = 4'b1101;
    step();
    req_valid = '0;
    repeat (L + 10) step();
    check("fr_hold", 32'(rsp_valid), 32'b0010);
    rsp_ready = 4'b0010;
    repeat (3) step();

    // Reset mid-BUSY, then requester 1 must win over 3.
    do_reset("pre_rb");
    req_valid = 4'b0001;
    step();
    req_valid = '0;
    repeat (4) step();
    do_reset("rb");
    req_valid = 4'b1010;
    rsp_ready = 4'b1111;
    step();
    check("rb_first", 32'(acc_id.size() == 1 ? acc_id[0] : -1), 32'd1);
    req_valid = '0;
    repeat (L + 4) step();

    // Requester 3 pulses only while the engine is busy.
    do_reset("wd");
    req_valid = 4'b0001;
    step();
    req_valid = '0;
    repeat (3) step();
    req_valid = 4'b1000;
    repeat (4) step();
    req_valid = '0;
    repeat (L + 4) step();
    check("wd_grants", 32'(acc_id.size()), 32'd1);

    // Randomized traffic, with occasional asynchronous reset.
    do_reset("rnd");
    for (int i = 0; i < 2500; i++) begin
      for (int k = 0; k < N; k++) begin
        req_valid[k] = ($urandom_range(0, 3) == 0);
        rsp_ready[k] = ($urandom_range(0, 9) < 7);
      end
      req_angle = {$urandom, $urandom};
      if ($urandom_range(0, 499) == 0) do_reset("rnd_rst");
      else step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
